// File: rtl/ce_gen.sv
// Lock-qualified fractional clock-enable generator: CHANNELS independent num/den
// strobes from one master clock, all phase-aligned when ready rises.
module ce_gen #(
    parameter int CHANNELS    = 4,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      locked,
    input  logic [CHANNELS*ACC_W-1:0] num,
    input  logic [CHANNELS*ACC_W-1:0] den,
    input  logic [CHANNELS-1:0]       enable,
    output logic                      ready,
    output logic [CHANNELS-1:0]       ce
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES);

    logic                            sync1_q, sync2_q;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            ready_q, ready_d;
    logic [CHANNELS-1:0][ACC_W-1:0]  acc_q, acc_d;
    logic [CHANNELS-1:0]             ce_q, ce_d;
    logic                            run;

    // One accumulation step in ACC_W+1 bits; returns {strobe, next accumulator}.
    // A remainder still >= den (num > den, or den lowered) is clamped to 0.
    function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] acc,
                                                input logic [ACC_W-1:0] n,
                                                input logic [ACC_W-1:0] d);
        logic [ACC_W:0] nxt;
        logic [ACC_W:0] rem;
        nxt = {1'b0, acc} + {1'b0, n};
        rem = nxt - {1'b0, d};
        if (nxt < {1'b0, d})
            return {1'b0, nxt[ACC_W-1:0]};
        if (rem >= {1'b0, d})
            return {1'b1, {ACC_W{1'b0}}};
        return {1'b1, rem[ACC_W-1:0]};
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= locked;
            sync2_q <= sync1_q;
        end
    end

    // Counter saturates at LOCK_CYCLES; ready follows it on the same edge.
    always_comb begin
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        if (!sync2_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q < CNT_MAX)
                cnt_d = cnt_q + CNT_W'(1);
            ready_d = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // A lock drop seen this edge clears every channel even though ready_q is still 1.
    assign run = ready_q & sync2_q;

    always_comb begin
        acc_d = '0;
        ce_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (run && enable[i] && (|den[i*ACC_W +: ACC_W]))
                {ce_d[i], acc_d[i]} = acc_step(acc_q[i],
                                               num[i*ACC_W +: ACC_W],
                                               den[i*ACC_W +: ACC_W]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            ce_q  <= '0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ready = ready_q;
    assign ce    = ce_q;

endmodule

// File: tb/tb_ce_gen.sv
// Scoreboard bench for ce_gen: stimulus queues per-edge expected ready/ce, a monitor
// pops and compares after every rising edge.
module tb_ce_gen;
    localparam int CH = 4;
    localparam int AW = 16;
    localparam int LC = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              locked;
    logic [CH*AW-1:0]  num, den;
    logic [CH-1:0]     enable;
    logic              ready;
    logic [CH-1:0]     ce;

    ce_gen #(.CHANNELS(CH), .ACC_W(AW), .LOCK_CYCLES(LC)) dut (
        .clock(clock), .reset(reset), .locked(locked), .num(num), .den(den),
        .enable(enable), .ready(ready), .ce(ce)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          rdy;
        logic [CH-1:0] ce;
        logic [CH-1:0] mask;
        string         name;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] pat1 = 8'b1010_0100;   // ch1 3/8: strobes on cycles 3, 6, 8

    task automatic cmp(string name, logic r, logic [CH-1:0] c,
                       logic er, logic [CH-1:0] ec, logic [CH-1:0] m);
        n_vec++;
        if (r !== er || (c & m) !== (ec & m)) begin
            n_err++;
            $display("FAIL %s @%0t: got ready=%b ce=%b, expected ready=%b ce=%b (mask %b)",
                     name, $time, r, c, er, ec, m);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, ready, ce, e.rdy, e.ce, e.mask);
            end
        end
    end

    task automatic tick(logic r, logic [CH-1:0] c, logic [CH-1:0] m, string name);
        exp_t e;
        e.rdy = r; e.ce = c; e.mask = m; e.name = name;
        sb.push_back(e);
        @(negedge clock);
    endtask

    task automatic set_ch(int i, logic [AW-1:0] n, logic [AW-1:0] d);
        num[i*AW +: AW] = n;
        den[i*AW +: AW] = d;
    endtask

    function automatic logic [CH-1:0] exp_a(int k);
        logic [CH-1:0] v;
        v[0] = (k % 16 == 0);
        v[1] = pat1[(k-1) % 8];
        v[2] = 1'b1;
        v[3] = 1'b1;
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_b(int k);
        logic [CH-1:0] v;
        v[0] = (k % 16 == 0);
        v[1] = pat1[(k-1) % 8];
        v[2] = 1'b0;
        v[3] = (k > 36) && ((k - 36) % 4 == 0);
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_c(int k);
        logic [CH-1:0] v;
        v[0] = (k % 4 == 0);
        if (k <= 5)      v[1] = (k % 4 == 0);
        else if (k < 8)  v[1] = 1'b0;
        else             v[1] = ((k - 7) % 4 == 0);
        v[2] = 1'b1;
        v[3] = 1'b0;
        return v;
    endfunction

    initial begin
        reset = 1'b0; locked = 1'b0; num = '0; den = '0; enable = '0;
        repeat (2) @(negedge clock);
        #1 cmp("reset_state", ready, ce, 1'b0, 4'h0, 4'hF);
        @(negedge clock);

        set_ch(0, 16'd1, 16'd16);
        set_ch(1, 16'd3, 16'd8);
        set_ch(2, 16'd5, 16'd5);
        set_ch(3, 16'hFFFF, 16'hFFFF);
        enable = 4'hF;
        reset  = 1'b1;

        // Lock glitch at sample 5 restarts the stability count.
        for (int e = 0; e < 15; e++) begin
            locked = (e != 5);
            tick(1'b0, 4'h0, 4'hF, "lock_glitch");
        end
        tick(1'b1, 4'h0, 4'hF, "ready_rise");

        for (int k = 1; k <= 32; k++)
            tick(1'b1, exp_a(k), 4'hF, "ratio_a");

        set_ch(2, 16'd0, 16'd5);
        set_ch(3, 16'd1, 16'd0);
        for (int k = 33; k <= 44; k++) begin
            if (k == 37) set_ch(3, 16'd1, 16'd4);
            tick(1'b1, exp_b(k), 4'hF, "boundary_b");
        end

        locked = 1'b0;
        set_ch(0, 16'd1, 16'd4);
        set_ch(1, 16'd1, 16'd4);
        set_ch(2, 16'd5, 16'd5);
        enable = 4'b0111;
        tick(1'b1, 4'h0, 4'h0, "drop_e0");
        tick(1'b1, 4'h0, 4'h0, "drop_e1");
        tick(1'b0, 4'h0, 4'hF, "drop_e2");
        tick(1'b0, 4'h0, 4'hF, "unlocked");
        locked = 1'b1;
        for (int e = 0; e < LC + 1; e++)
            tick(1'b0, 4'h0, 4'hF, "relock_wait");
        tick(1'b1, 4'h0, 4'hF, "relock_rise");

        for (int k = 1; k <= 20; k++) begin
            if (k == 6) enable[1] = 1'b0;
            if (k == 8) enable[1] = 1'b1;
            tick(1'b1, exp_c(k), 4'hF, "phase_c");
        end

        #2 reset = 1'b0;
        #1 cmp("async_reset", ready, ce, 1'b0, 4'h0, 4'hF);
        @(negedge clock);
        reset = 1'b1;
        for (int e = 0; e < LC + 1; e++)
            tick(1'b0, 4'h0, 4'hF, "post_reset_wait");
        tick(1'b1, 4'h0, 4'hF, "post_reset_rise");
        for (int k = 1; k <= 8; k++)
            tick(1'b1, {1'b0, 1'b1, (k % 4 == 0), (k % 4 == 0)}, 4'hF, "realign");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ce_gen.md
Name: ce_gen

Overview:
- Parametrised successor to the fixed single-ratio clock generator.
- Takes the one synthesised master clock plus the clock generator's raw lock flag.
- Produces CHANNELS independent fractional clock-enable strobes (CPU, ULA, audio, etc.), each with a run-time ratio num/den.
- Gates all strobes behind a lock-qualified ready and phase-aligns every channel on ready rise.

Parameters:
- CHANNELS, 4, number of independent enable channels
- ACC_W, 16, width of each channel's num, den and phase accumulator
- LOCK_CYCLES, 1024, consecutive synchronised lock samples required before ready asserts (>=1)

Ports:
- clock  in  1  master clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- locked  in  1  raw lock flag from the clock generator, asynchronous to clock
- num  in  CHANNELS*ACC_W  per-channel numerator, channel i at bits [i*ACC_W +: ACC_W]
- den  in  CHANNELS*ACC_W  per-channel denominator, same packing
- enable  in  CHANNELS  per-channel run enable
- ready  out  1  lock qualified and stable
- ce  out  CHANNELS  per-channel one-cycle enable strobes, registered

Behaviour:
- Reset (reset=0, async):
  - ready=0, ce=0.
  - Lock synchroniser flops, stability counter and all accumulators = 0.
- Lock synchroniser: locked passes through 2 flops to give locked_s.
- Stability counter (width clog2(LOCK_CYCLES+1)):
  - locked_s=0 -> counter=0, ready=0 on the same edge.
  - locked_s=1 and counter<LOCK_CYCLES -> counter+1.
  - ready is registered: it goes 1 on the edge where the counter reaches LOCK_CYCLES, then holds while locked_s=1.
  - Net latency: first edge sampling locked=1 is edge 0 -> ready=1 after edge LOCK_CYCLES+1.
- Loss of lock:
  - Any locked_s=0 clears ready and all accumulators on that edge.
  - All ce are 0 from the following cycle.
  - A glitch shorter than one clock may be missed by the synchroniser; that is acceptable.
- Channel i, each edge with ready=1 (evaluated in ACC_W+1 bits):
  - den_i==0 or enable_i==0 -> acc_i=0, ce_i=0.
  - Otherwise nxt = acc_i + num_i.
  - nxt >= den_i -> ce_i=1 and acc_i = nxt - den_i. If the result is still >= den_i (num_i > den_i, or den_i lowered), clamp acc_i=0.
  - nxt < den_i -> ce_i=0 and acc_i = nxt.
- Ratio rules:
  - num_i=0 -> ce_i never asserts.
  - num_i >= den_i > 0 -> ce_i high every cycle.
  - Long-run ce rate = num/den exactly for num<den.
- ready=0: acc_i held at 0, ce_i=0.
- Phase alignment: every accumulator starts from 0 on the first ready=1 cycle, so channels with equal den pulse in phase.
- Runtime changes:
  - num/den/enable are sampled every edge and take effect on the next accumulation, with no restart.
  - Deasserting enable_i clears acc_i. Re-enabling restarts that channel from phase 0.
- Overflow: nxt carries in bit ACC_W, so no wrap-around. Max values (all-ones num and den) must behave per the rules above.

Test Plan:
- Reset asserted mid-count with ready=1 -> ready, ce go 0 asynchronously. After release with locked=1 held, ready returns exactly LOCK_CYCLES+2 edges later.
- LOCK_CYCLES=8, locked pulses 0 at sample 5 -> counter restarts. Ready rises only after 8 further consecutive samples. Dropping locked while ready -> ready=0 and ce=0 within 3 edges.
- ch0 num=1 den=16 -> ce0 high on ready-cycles 16,32,48,... (1 of every 16, 56.75 MHz -> 3.55 MHz).
- ch1 num=3 den=8 -> ce1 high on ready-cycles 3,6,8 of each 8-cycle period, repeating exactly. Accumulator returns to 0 every 8 cycles.
- Boundaries:
  - ch2 num=5 den=5 -> ce2 every cycle.
  - ch2 num=0 -> never.
  - ch2 den=0 -> never, acc=0.
  - ch3 num=16'hFFFF den=16'hFFFF -> every cycle, no wrap.
- ch0 and ch1 both num=1 den=4 -> identical ce pulses. Toggle enable1 low for 2 cycles at arbitrary phase -> ch1 restarts from 0, first pulse on the 4th cycle after re-enable, ch0 unaffected.
